neo_pal_out: RTL and testbench

- Palette stage directly downstream of the palette address generator.
- Owns the 2-bank x 4096 x 16-bit palette RAM and resolves CPU palette accesses against the video fetch slot.
- Turns the 12-bit palette address (PA) into 8-bit-per-channel RGB, applying the dark, shadow and blank rules.
- Output feeds the video encoder / scaler.

---
 rtl/neo_pal_out_if.sv | 21 ++
 rtl/neo_pal_out.sv | 157 +++++++++++++++
 tb/tb_neo_pal_out.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/neo_pal_out_if.sv
// CPU palette access bus: single-cycle request strobes, shared address, ACK-qualified read data.
interface neo_pal_out_if #(
    parameter int unsigned AW = 12
);
    logic          CPU_WR;
    logic          CPU_RD;
    logic [AW-1:0] CPU_ADDR;
    logic [15:0]   CPU_DIN;
    logic [15:0]   CPU_DOUT;
    logic          CPU_ACK;

    modport master (
        output CPU_WR, CPU_RD, CPU_ADDR, CPU_DIN,
        input  CPU_DOUT, CPU_ACK
    );

    modport slave (
        input  CPU_WR, CPU_RD, CPU_ADDR, CPU_DIN,
        output CPU_DOUT, CPU_ACK
    );
endinterface

// File: rtl/neo_pal_out.sv
// Palette stage: owns the 2-bank palette RAM, shares it between video fetch and CPU
// accesses, and expands 16-bit palette words into 8-bit RGB with dark/shadow/blank rules.
module neo_pal_out #(
    parameter int unsigned AW        = 12,
    parameter int unsigned BLANK_DLY = 2
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 CLK_EN_6MB,
    input  logic [AW-1:0]        PA,
    input  logic                 PALBNK,
    input  logic                 SHADOW,
    input  logic                 BLANK,
    neo_pal_out_if.slave         bus,
    output logic [7:0]           R,
    output logic [7:0]           G,
    output logic [7:0]           B,
    output logic                 BLANK_O
);
    typedef enum logic {CPU_IDLE, CPU_RD_CAPT} cpu_st_t;

    logic [15:0] mem [2**(AW+1)];
    logic [15:0] ram_rdata_q;
    logic        ram_we;
    logic [AW:0] ram_addr;
    logic [15:0] ram_wdata;

    cpu_st_t              cpu_st_q, cpu_st_d;
    logic                 wrp_q, wrp_d, rdp_q, rdp_d;
    logic [AW-1:0]        wr_addr_q, wr_addr_d, rd_addr_q, rd_addr_d;
    logic [15:0]          wr_data_q, wr_data_d;
    logic [15:0]          dout_q, dout_d;
    logic                 ack_q, ack_d;
    logic                 vid_rd_q, vid_rd_d;
    logic [15:0]          col_q, col_d;
    logic [BLANK_DLY-1:0] blank_sr_q, blank_sr_d;
    logic [7:0]           r_q, r_d, g_q, g_d, b_q, b_d;
    logic                 wr_clr, rd_clr;

    function automatic logic [7:0] chan(input logic [3:0] c, input logic c0,
                                        input logic dark, input logic shadow);
        logic [4:0] c5;
        logic [7:0] c8;
        c5 = {c, c0};
        c8 = {c5, c5[4:2]};
        if (dark)
            c8 = (c8 >= 8'd4) ? c8 - 8'd4 : '0;
        if (shadow)
            c8 = c8 >> 1;
        return c8;
    endfunction

    always_ff @(posedge CLK) begin
        if (ram_we)
            mem[ram_addr] <= ram_wdata;
        ram_rdata_q <= mem[ram_addr];
    end

    always_comb begin
        cpu_st_d  = cpu_st_q;
        ack_d     = 1'b0;
        dout_d    = dout_q;
        wr_clr    = 1'b0;
        rd_clr    = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = {PALBNK, PA};
        ram_wdata = wr_data_q;

        // A read capture takes priority over any new service so ACKs never coincide;
        // on a video slot the port still goes to the video fetch.
        if (cpu_st_q == CPU_RD_CAPT) begin
            dout_d   = ram_rdata_q;
            ack_d    = 1'b1;
            rd_clr   = 1'b1;
            cpu_st_d = CPU_IDLE;
        end else if (!CLK_EN_6MB) begin
            if (wrp_q) begin
                ram_we   = 1'b1;
                ram_addr = {PALBNK, wr_addr_q};
                wr_clr   = 1'b1;
                ack_d    = 1'b1;
            end else if (rdp_q) begin
                ram_addr = {PALBNK, rd_addr_q};
                cpu_st_d = CPU_RD_CAPT;
            end
        end

        wrp_d     = bus.CPU_WR ? 1'b1 : (wr_clr ? 1'b0 : wrp_q);
        rdp_d     = bus.CPU_RD ? 1'b1 : (rd_clr ? 1'b0 : rdp_q);
        wr_addr_d = bus.CPU_WR ? bus.CPU_ADDR : wr_addr_q;
        wr_data_d = bus.CPU_WR ? bus.CPU_DIN  : wr_data_q;
        rd_addr_d = bus.CPU_RD ? bus.CPU_ADDR : rd_addr_q;
    end

    always_comb begin
        vid_rd_d   = CLK_EN_6MB;
        col_d      = vid_rd_q ? ram_rdata_q : col_q;
        blank_sr_d = blank_sr_q;
        r_d        = r_q;
        g_d        = g_q;
        b_d        = b_q;
        if (CLK_EN_6MB) begin
            blank_sr_d = BLANK_DLY'({blank_sr_q, BLANK});
            // blank_sr_q[0] is BLANK from the enable that fetched col_q
            if (blank_sr_q[0]) begin
                r_d = '0;
                g_d = '0;
                b_d = '0;
            end else begin
                r_d = chan(col_q[11:8], col_q[14], col_q[15], SHADOW);
                g_d = chan(col_q[7:4],  col_q[13], col_q[15], SHADOW);
                b_d = chan(col_q[3:0],  col_q[12], col_q[15], SHADOW);
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cpu_st_q   <= CPU_IDLE;
            wrp_q      <= 1'b0;
            rdp_q      <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            rd_addr_q  <= '0;
            dout_q     <= '0;
            ack_q      <= 1'b0;
            vid_rd_q   <= 1'b0;
            col_q      <= '0;
            blank_sr_q <= '1;
            r_q        <= '0;
            g_q        <= '0;
            b_q        <= '0;
        end else begin
            cpu_st_q   <= cpu_st_d;
            wrp_q      <= wrp_d;
            rdp_q      <= rdp_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            rd_addr_q  <= rd_addr_d;
            dout_q     <= dout_d;
            ack_q      <= ack_d;
            vid_rd_q   <= vid_rd_d;
            col_q      <= col_d;
            blank_sr_q <= blank_sr_d;
            r_q        <= r_d;
            g_q        <= g_d;
            b_q        <= b_d;
        end
    end

    assign R            = r_q;
    assign G            = g_q;
    assign B            = b_q;
    assign BLANK_O      = blank_sr_q[BLANK_DLY-1];
    assign bus.CPU_DOUT = dout_q;
    assign bus.CPU_ACK  = ack_q;
endmodule

// File: tb/tb_neo_pal_out.sv
// Directed bench for neo_pal_out: CPU access, colour expansion, bank select,
// slot contention and asynchronous reset.
module tb_neo_pal_out;
    logic        CLK;
    logic        RST;
    logic        CLK_EN_6MB;
    logic [11:0] PA;
    logic        PALBNK;
    logic        SHADOW;
    logic        BLANK;
    logic [7:0]  R, G, B;
    logic        BLANK_O;

    int n_cmp = 0;
    int n_bad = 0;

    neo_pal_out_if #(.AW(12)) bus ();

    neo_pal_out #(.AW(12), .BLANK_DLY(2)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .CLK_EN_6MB (CLK_EN_6MB),
        .PA         (PA),
        .PALBNK     (PALBNK),
        .SHADOW     (SHADOW),
        .BLANK      (BLANK),
        .bus        (bus),
        .R          (R),
        .G          (G),
        .B          (B),
        .BLANK_O    (BLANK_O)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #500000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic pixel();
        CLK_EN_6MB = 1'b1;
        tick();
        CLK_EN_6MB = 1'b0;
        tick();
    endtask

    task automatic cpu_write(input logic bank, input logic [11:0] addr, input logic [15:0] data);
        logic got;
        got          = 1'b0;
        PALBNK       = bank;
        bus.CPU_WR   = 1'b1;
        bus.CPU_ADDR = addr;
        bus.CPU_DIN  = data;
        tick();
        bus.CPU_WR   = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (bus.CPU_ACK) begin
                got = 1'b1;
                break;
            end
        end
        check("wr_ack", 32'(got), 32'd1);
    endtask

    task automatic cpu_read(input logic bank, input logic [11:0] addr, input logic [15:0] exp);
        logic got;
        got          = 1'b0;
        PALBNK       = bank;
        bus.CPU_RD   = 1'b1;
        bus.CPU_ADDR = addr;
        tick();
        bus.CPU_RD   = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (bus.CPU_ACK) begin
                got = 1'b1;
                break;
            end
        end
        check("rd_ack", 32'(got), 32'd1);
        check("rd_data", 32'(bus.CPU_DOUT), 32'(exp));
    endtask

    task automatic vid(input string tag, input logic [15:0] data, input logic sh,
                       input logic [7:0] er, input logic [7:0] eg, input logic [7:0] eb);
        cpu_write(1'b0, 12'h010, data);
        PA     = 12'h010;
        SHADOW = sh;
        pixel();
        pixel();
        check({tag, "_r"}, 32'(R), 32'(er));
        check({tag, "_g"}, 32'(G), 32'(eg));
        check({tag, "_b"}, 32'(B), 32'(eb));
    endtask

    initial begin
        logic        any_ack;
        logic [15:0] d;

        RST          = 1'b1;
        CLK_EN_6MB   = 1'b0;
        PA           = 12'h010;
        PALBNK       = 1'b0;
        SHADOW       = 1'b0;
        BLANK        = 1'b0;
        bus.CPU_WR   = 1'b0;
        bus.CPU_RD   = 1'b0;
        bus.CPU_ADDR = '0;
        bus.CPU_DIN  = '0;
        #1;
        check("rst_r", 32'(R), 32'd0);
        check("rst_blank_o", 32'(BLANK_O), 32'd1);
        check("rst_dout", 32'(bus.CPU_DOUT), 32'd0);
        check("rst_ack", 32'(bus.CPU_ACK), 32'd0);
        tick();
        tick();
        RST = 1'b0;
        tick();

        // CPU write then read back, ACK is a single pulse
        cpu_write(1'b0, 12'h010, 16'h7FFF);
        tick();
        check("wr_ack_single", 32'(bus.CPU_ACK), 32'd0);
        cpu_read(1'b0, 12'h010, 16'h7FFF);

        // Colour expansion, dark saturation, shadow
        vid("v7fff", 16'h7FFF, 1'b0, 8'hFF, 8'hFF, 8'hFF);
        check("blank_o_low", 32'(BLANK_O), 32'd0);
        vid("v8000", 16'h8000, 1'b0, 8'h00, 8'h00, 8'h00);
        vid("vffff", 16'hFFFF, 1'b0, 8'hFB, 8'hFB, 8'hFB);
        vid("vffff_sh", 16'hFFFF, 1'b1, 8'h7D, 8'h7D, 8'h7D);
        vid("v7fff_sh", 16'h7FFF, 1'b1, 8'h7F, 8'h7F, 8'h7F);
        vid("v4f00", 16'h4F00, 1'b0, 8'hFF, 8'h00, 8'h00);
        vid("v0840", 16'h0840, 1'b0, 8'h84, 8'h42, 8'h00);
        vid("v0420", 16'h0420, 1'b0, 8'h42, 8'h21, 8'h00);
        vid("v8100", 16'h8100, 1'b0, 8'h0C, 8'h00, 8'h00);
        vid("v300f", 16'h300F, 1'b0, 8'h00, 8'h08, 8'hFF);

        // BLANK travels two enables, then forces black
        BLANK = 1'b1;
        pixel();
        check("blank_1en_o", 32'(BLANK_O), 32'd0);
        check("blank_1en_g", 32'(G), 32'h08);
        pixel();
        check("blank_2en_o", 32'(BLANK_O), 32'd1);
        check("blank_2en_rgb", 32'({R, G, B}), 32'h000000);
        BLANK = 1'b0;
        pixel();
        pixel();
        check("unblank_o", 32'(BLANK_O), 32'd0);
        check("unblank_b", 32'(B), 32'hFF);

        // Bank select
        cpu_write(1'b1, 12'h005, 16'h1234);
        cpu_write(1'b0, 12'h005, 16'h0000);
        PA     = 12'h005;
        PALBNK = 1'b0;
        pixel();
        pixel();
        check("bank0_rgb", 32'({R, G, B}), 32'h000000);
        PALBNK = 1'b1;
        pixel();
        check("bank1_1en", 32'({R, G, B}), 32'h000000);
        pixel();
        check("bank1_2en", 32'({R, G, B}), 32'h21314A);
        PALBNK = 1'b0;
        pixel();
        check("bank0_1en", 32'({R, G, B}), 32'h21314A);
        pixel();
        check("bank0_2en", 32'({R, G, B}), 32'h000000);

        // CPU read whose capture cycle lands on a video slot
        cpu_write(1'b0, 12'h010, 16'h7FFF);
        cpu_write(1'b0, 12'h020, 16'hABCD);
        PA           = 12'h010;
        bus.CPU_RD   = 1'b1;
        bus.CPU_ADDR = 12'h020;
        tick();
        bus.CPU_RD   = 1'b0;
        tick();
        check("vcap_issue_ack", 32'(bus.CPU_ACK), 32'd0);
        CLK_EN_6MB = 1'b1;
        tick();
        CLK_EN_6MB = 1'b0;
        check("vcap_ack", 32'(bus.CPU_ACK), 32'd1);
        check("vcap_dout", 32'(bus.CPU_DOUT), 32'hABCD);
        tick();
        pixel();
        check("vcap_rgb", 32'({R, G, B}), 32'hFFFFFF);

        // Strobe arriving as its flag clears stays pending
        bus.CPU_WR   = 1'b1;
        bus.CPU_ADDR = 12'h030;
        bus.CPU_DIN  = 16'h1111;
        tick();
        bus.CPU_ADDR = 12'h031;
        bus.CPU_DIN  = 16'h2222;
        tick();
        bus.CPU_WR   = 1'b0;
        check("reload_ack1", 32'(bus.CPU_ACK), 32'd1);
        tick();
        check("reload_ack2", 32'(bus.CPU_ACK), 32'd1);
        tick();
        check("reload_ack_end", 32'(bus.CPU_ACK), 32'd0);
        cpu_read(1'b0, 12'h030, 16'h1111);
        cpu_read(1'b0, 12'h031, 16'h2222);

        // Contention: WR+RD on every enable cycle, same address
        for (int i = 0; i < 100; i++) begin
            d            = 16'(i * 16'h0101) ^ 16'h5A5A;
            CLK_EN_6MB   = 1'b1;
            bus.CPU_WR   = 1'b1;
            bus.CPU_RD   = 1'b1;
            bus.CPU_ADDR = 12'(12'h100 + i);
            bus.CPU_DIN  = d;
            tick();
            CLK_EN_6MB   = 1'b0;
            bus.CPU_WR   = 1'b0;
            bus.CPU_RD   = 1'b0;
            check("cont_vslot_ack", 32'(bus.CPU_ACK), 32'd0);
            tick();
            check("cont_wr_ack", 32'(bus.CPU_ACK), 32'd1);
            tick();
            check("cont_gap_ack", 32'(bus.CPU_ACK), 32'd0);
            tick();
            check("cont_rd_ack", 32'(bus.CPU_ACK), 32'd1);
            check("cont_rd_data", 32'(bus.CPU_DOUT), 32'(d));
            check("cont_rgb", 32'({R, G, B}), 32'hFFFFFF);
        end
        cpu_read(1'b0, 12'h105, 16'h5F5F);

        // Reset with a read pending: no ACK, outputs forced immediately
        bus.CPU_RD   = 1'b1;
        bus.CPU_ADDR = 12'h010;
        tick();
        bus.CPU_RD   = 1'b0;
        #2;
        RST = 1'b1;
        #1;
        check("rstmid_ack", 32'(bus.CPU_ACK), 32'd0);
        check("rstmid_rgb", 32'({R, G, B}), 32'h000000);
        check("rstmid_blank_o", 32'(BLANK_O), 32'd1);
        any_ack = 1'b0;
        tick();
        any_ack |= bus.CPU_ACK;
        tick();
        any_ack |= bus.CPU_ACK;
        RST = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            any_ack |= bus.CPU_ACK;
        end
        check("rstmid_no_ack", 32'(any_ack), 32'd0);
        check("rstmid_dout", 32'(bus.CPU_DOUT), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
